// File: rtl/pipeline_sequencer_if.sv
// Control bundle between the pipeline sequencer (slave) and the datapath (master).
// The datapath reports hazard and hit status; the sequencer returns enables, flushes and counters.
interface pipeline_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             ihit;
  logic             dhit;
  logic [4:0]       fd_rs;
  logic [4:0]       fd_rt;
  logic [4:0]       de_rt;
  logic             de_dcuREN;
  logic             em_dcuREN;
  logic             em_dcuWEN;
  logic             em_redirect;
  logic             mw_halt;
  logic             pc_en;
  logic             fd_en;
  logic             de_en;
  logic             em_en;
  logic             mw_en;
  logic             fd_flush;
  logic             de_flush;
  logic             em_flush;
  logic             mw_flush;
  logic             dmem_req;
  logic             halt;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport slave (
    input  ihit, dhit, fd_rs, fd_rt, de_rt, de_dcuREN,
           em_dcuREN, em_dcuWEN, em_redirect, mw_halt,
    output pc_en, fd_en, de_en, em_en, mw_en,
           fd_flush, de_flush, em_flush, mw_flush,
           dmem_req, halt, stall_cnt, flush_cnt
  );

  modport master (
    output ihit, dhit, fd_rs, fd_rt, de_rt, de_dcuREN,
           em_dcuREN, em_dcuWEN, em_redirect, mw_halt,
    input  pc_en, fd_en, de_en, em_en, mw_en,
           fd_flush, de_flush, em_flush, mw_flush,
           dmem_req, halt, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_sequencer.sv
// Five-stage pipeline sequencer: resolves halt, data-wait, redirect, load-use and
// fetch-wait hazards into per-latch enables/flushes, with saturating stall/flush counters.
module pipeline_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  pipeline_sequencer_if.slave  bus,
  output logic [1:0]           state_dbg
);
  localparam logic [1:0] S_RUN    = 2'd0;
  localparam logic [1:0] S_DWAIT  = 2'd1;
  localparam logic [1:0] S_HALTED = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  logic mem_op;
  logic load_use;
  logic redirect_taken;
  logic pc_en_c, fd_en_c, de_en_c, em_en_c, mw_en_c;
  logic fd_flush_c, de_flush_c, em_flush_c, mw_flush_c;
  logic dmem_req_c;

  assign mem_op   = bus.em_dcuREN | bus.em_dcuWEN;
  assign load_use = bus.de_dcuREN && (bus.de_rt != 5'd0) &&
                    ((bus.de_rt == bus.fd_rs) || (bus.de_rt == bus.fd_rt));

  // Priority: halt > data wait > redirect > load-use > fetch wait > advance.
  always_comb begin
    state_nxt      = state;
    redirect_taken = 1'b0;
    pc_en_c        = 1'b0;
    fd_en_c        = 1'b0;
    de_en_c        = 1'b0;
    em_en_c        = 1'b0;
    mw_en_c        = 1'b0;
    fd_flush_c     = 1'b0;
    de_flush_c     = 1'b0;
    em_flush_c     = 1'b0;
    mw_flush_c     = 1'b0;
    dmem_req_c     = 1'b0;
    if (RST) begin
      state_nxt = S_RUN;
    end else if (state != S_HALTED) begin
      dmem_req_c = mem_op;
      if (bus.mw_halt) begin
        state_nxt = S_HALTED;
      end else if (mem_op && !bus.dhit) begin
        mw_flush_c = 1'b1;
        state_nxt  = S_DWAIT;
      end else begin
        state_nxt = S_RUN;
        if (state == S_DWAIT) begin
          // The completing access releases the whole pipe at once.
          {pc_en_c, fd_en_c, de_en_c, em_en_c, mw_en_c} = 5'b11111;
        end else if (bus.em_redirect) begin
          redirect_taken = 1'b1;
          pc_en_c        = 1'b1;
          mw_en_c        = 1'b1;
          fd_flush_c     = 1'b1;
          de_flush_c     = 1'b1;
          em_flush_c     = 1'b1;
        end else if (load_use || !bus.ihit) begin
          de_flush_c = 1'b1;
          em_en_c    = 1'b1;
          mw_en_c    = 1'b1;
        end else begin
          {pc_en_c, fd_en_c, de_en_c, em_en_c, mw_en_c} = 5'b11111;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= S_RUN;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state <= state_nxt;
      if ((state != S_HALTED) && !pc_en_c && (stall_q != '1))
        stall_q <= stall_q + CNT_W'(1);
      if (redirect_taken && (flush_q != '1))
        flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign bus.pc_en     = pc_en_c;
  assign bus.fd_en     = fd_en_c;
  assign bus.de_en     = de_en_c;
  assign bus.em_en     = em_en_c;
  assign bus.mw_en     = mw_en_c;
  assign bus.fd_flush  = fd_flush_c;
  assign bus.de_flush  = de_flush_c;
  assign bus.em_flush  = em_flush_c;
  assign bus.mw_flush  = mw_flush_c;
  assign bus.dmem_req  = dmem_req_c;
  assign bus.halt      = (state == S_HALTED);
  assign bus.stall_cnt = stall_q;
  assign bus.flush_cnt = flush_q;
  assign state_dbg     = state;
endmodule

// File: tb/tb_pipeline_sequencer.sv
// Bench for pipeline_sequencer: directed hazard scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_pipeline_sequencer;
  logic clk;
  logic rst;
  logic ihit, dhit, de_dcuREN, em_dcuREN, em_dcuWEN, em_redirect, mw_halt;
  logic [4:0] fd_rs, fd_rt, de_rt;
  logic [1:0] dbg16, dbg4;

  int total = 0;
  int bad   = 0;

  pipeline_sequencer_if #(.CNT_W(16)) sif ();
  pipeline_sequencer_if #(.CNT_W(4))  sif4 ();

  assign sif.ihit = ihit;          assign sif4.ihit = ihit;
  assign sif.dhit = dhit;          assign sif4.dhit = dhit;
  assign sif.fd_rs = fd_rs;        assign sif4.fd_rs = fd_rs;
  assign sif.fd_rt = fd_rt;        assign sif4.fd_rt = fd_rt;
  assign sif.de_rt = de_rt;        assign sif4.de_rt = de_rt;
  assign sif.de_dcuREN = de_dcuREN;     assign sif4.de_dcuREN = de_dcuREN;
  assign sif.em_dcuREN = em_dcuREN;     assign sif4.em_dcuREN = em_dcuREN;
  assign sif.em_dcuWEN = em_dcuWEN;     assign sif4.em_dcuWEN = em_dcuWEN;
  assign sif.em_redirect = em_redirect; assign sif4.em_redirect = em_redirect;
  assign sif.mw_halt = mw_halt;    assign sif4.mw_halt = mw_halt;

  pipeline_sequencer #(.CNT_W(16)) u_dut (
    .CLK(clk), .RST(rst), .bus(sif.slave), .state_dbg(dbg16)
  );
  pipeline_sequencer #(.CNT_W(4)) u_dut4 (
    .CLK(clk), .RST(rst), .bus(sif4.slave), .state_dbg(dbg4)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural model: {pc,fd,de,em,mw enables, fd,de,em,mw flushes, dmem_req}
  typedef struct packed {
    logic pc, fd, de, em, mw, fdf, def, emf, mwf, dreq;
  } ctl_t;

  bit m_wait   = 1'b0;
  bit m_halted = 1'b0;
  int s16 = 0, f16 = 0, s4 = 0, f4 = 0;

  function automatic ctl_t model_ctl();
    ctl_t c;
    logic mem;
    logic lu;
    c   = '0;
    mem = em_dcuREN | em_dcuWEN;
    lu  = de_dcuREN && (de_rt != 5'd0) && ((de_rt == fd_rs) || (de_rt == fd_rt));
    if (rst || m_halted) return c;
    c.dreq = mem;
    if (mw_halt) return c;
    if (mem && !dhit) begin
      c.mwf = 1'b1;
      return c;
    end
    if (m_wait || (!em_redirect && !lu && ihit)) begin
      {c.pc, c.fd, c.de, c.em, c.mw} = 5'b11111;
    end else if (em_redirect) begin
      c.pc = 1'b1; c.mw = 1'b1;
      c.fdf = 1'b1; c.def = 1'b1; c.emf = 1'b1;
    end else begin
      c.em = 1'b1; c.mw = 1'b1; c.def = 1'b1;
    end
    return c;
  endfunction

  function automatic int sat(input int v, input int maxv);
    return (v < maxv) ? v + 1 : v;
  endfunction

  always @(posedge clk) begin
    ctl_t c;
    c = model_ctl();
    if (rst) begin
      m_wait = 1'b0; m_halted = 1'b0;
      s16 = 0; f16 = 0; s4 = 0; f4 = 0;
    end else if (!m_halted) begin
      if (!c.pc) begin s16 = sat(s16, 65535); s4 = sat(s4, 15); end
      if (c.fdf) begin f16 = sat(f16, 65535); f4 = sat(f4, 15); end
      if (mw_halt) begin
        m_halted = 1'b1;
        m_wait   = 1'b0;
      end else begin
        m_wait = (em_dcuREN | em_dcuWEN) && !dhit;
      end
    end
  end

  // scoreboard check
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ctl_t dut_ctl16();
    return {sif.pc_en, sif.fd_en, sif.de_en, sif.em_en, sif.mw_en,
            sif.fd_flush, sif.de_flush, sif.em_flush, sif.mw_flush, sif.dmem_req};
  endfunction

  function automatic ctl_t dut_ctl4();
    return {sif4.pc_en, sif4.fd_en, sif4.de_en, sif4.em_en, sif4.mw_en,
            sif4.fd_flush, sif4.de_flush, sif4.em_flush, sif4.mw_flush, sif4.dmem_req};
  endfunction

  // compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    ctl_t e;
    e = model_ctl();
    chk("ctl16", 32'(dut_ctl16()), 32'(e));
    chk("ctl4", 32'(dut_ctl4()), 32'(e));
    chk("halt", 32'(sif.halt), 32'(m_halted));
    chk("stall16", 32'(sif.stall_cnt), s16);
    chk("flush16", 32'(sif.flush_cnt), f16);
    chk("stall4", 32'(sif4.stall_cnt), s4);
    chk("flush4", 32'(sif4.flush_cnt), f4);
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    ihit = 1'b1; dhit = 1'b1;
    fd_rs = 5'd0; fd_rt = 5'd0; de_rt = 5'd0;
    de_dcuREN = 1'b0; em_dcuREN = 1'b0; em_dcuWEN = 1'b0;
    em_redirect = 1'b0; mw_halt = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    set_idle();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    set_idle();
    repeat (2) tick();
    @(negedge clk);
    chk("rst_pc_en", 32'(sif.pc_en), 0);
    chk("rst_halt", 32'(sif.halt), 0);
    chk("rst_stall", 32'(sif.stall_cnt), 0);
    tick();
    rst = 1'b0;

    // load-use
    pulse_reset();
    tick();
    de_dcuREN = 1'b1; de_rt = 5'd8; fd_rs = 5'd8;
    @(negedge clk);
    chk("lu_pc_en", 32'(sif.pc_en), 0);
    chk("lu_fd_en", 32'(sif.fd_en), 0);
    chk("lu_de_flush", 32'(sif.de_flush), 1);
    chk("lu_em_en", 32'(sif.em_en), 1);
    chk("lu_stall_before", 32'(sif.stall_cnt), 0);
    tick();
    set_idle();
    @(negedge clk);
    chk("lu_stall_after", 32'(sif.stall_cnt), 1);
    chk("lu_release_pc_en", 32'(sif.pc_en), 1);
    tick();

    // data wait for three cycles, then hit
    pulse_reset();
    em_dcuREN = 1'b1; dhit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("dw_mw_flush", 32'(sif.mw_flush), 1);
      chk("dw_dmem_req", 32'(sif.dmem_req), 1);
      chk("dw_pc_en", 32'(sif.pc_en), 0);
      tick();
    end
    dhit = 1'b1;
    @(negedge clk);
    chk("dw_hit_enables", 32'({sif.pc_en, sif.fd_en, sif.de_en, sif.em_en, sif.mw_en}), 32'h1f);
    chk("dw_hit_dmem_req", 32'(sif.dmem_req), 1);
    tick();
    set_idle();
    ihit = 1'b0;
    @(negedge clk);
    chk("dw_back_in_run", 32'(sif.de_flush), 1);
    chk("dw_stall", 32'(sif.stall_cnt), 3);
    tick();

    // redirect beats load-use and fetch wait
    pulse_reset();
    em_redirect = 1'b1; de_dcuREN = 1'b1; de_rt = 5'd8; fd_rs = 5'd8; ihit = 1'b0;
    @(negedge clk);
    chk("rd_flushes", 32'({sif.fd_flush, sif.de_flush, sif.em_flush}), 32'h7);
    chk("rd_pc_en", 32'(sif.pc_en), 1);
    tick();
    set_idle();
    @(negedge clk);
    chk("rd_flush_cnt", 32'(sif.flush_cnt), 1);
    chk("rd_stall_cnt", 32'(sif.stall_cnt), 0);
    tick();

    // data wait beats redirect
    pulse_reset();
    em_dcuWEN = 1'b1; dhit = 1'b0; em_redirect = 1'b1;
    @(negedge clk);
    chk("dwr_front_flushes", 32'({sif.fd_flush, sif.de_flush, sif.em_flush}), 0);
    chk("dwr_mw_flush", 32'(sif.mw_flush), 1);
    chk("dwr_pc_en", 32'(sif.pc_en), 0);
    tick();
    set_idle();

    // halt is sticky until reset
    pulse_reset();
    mw_halt = 1'b1;
    @(negedge clk);
    chk("hl_enables", 32'({sif.pc_en, sif.fd_en, sif.de_en, sif.em_en, sif.mw_en}), 0);
    tick();
    mw_halt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ihit = i[0]; dhit = ~i[0]; em_dcuREN = 1'b1;
      @(negedge clk);
      chk("hl_halt", 32'(sif.halt), 1);
      chk("hl_enables_held", 32'({sif.pc_en, sif.fd_en, sif.de_en, sif.em_en, sif.mw_en}), 0);
      chk("hl_dmem_req", 32'(sif.dmem_req), 0);
      tick();
    end
    rst = 1'b1;
    set_idle();
    @(negedge clk);
    chk("hl_rst_enables", 32'({sif.pc_en, sif.fd_en, sif.de_en, sif.em_en, sif.mw_en}), 0);
    tick();
    rst = 1'b0;
    ihit = 1'b0;
    @(negedge clk);
    chk("hl_cleared", 32'(sif.halt), 0);
    chk("hl_stall_cleared", 32'(sif.stall_cnt), 0);
    chk("hl_flush_cleared", 32'(sif.flush_cnt), 0);
    chk("hl_run_after_rst", 32'(sif.de_flush), 1);
    tick();

    // saturation of the narrow counter
    pulse_reset();
    ihit = 1'b0;
    repeat (20) tick();
    @(negedge clk);
    chk("sat_stall4", 32'(sif4.stall_cnt), 15);
    chk("sat_stall16", 32'(sif.stall_cnt), 20);
    tick();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst         = ($urandom_range(0, 99) == 0);
      mw_halt     = ($urandom_range(0, 199) == 0);
      ihit        = ($urandom_range(0, 3) != 0);
      dhit        = ($urandom_range(0, 2) != 0);
      em_dcuREN   = ($urandom_range(0, 3) == 0);
      em_dcuWEN   = ($urandom_range(0, 3) == 0);
      em_redirect = ($urandom_range(0, 7) == 0);
      de_dcuREN   = ($urandom_range(0, 2) == 0);
      de_rt       = 5'($urandom_range(0, 3));
      fd_rs       = 5'($urandom_range(0, 3));
      fd_rt       = 5'($urandom_range(0, 3));
      tick();
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipeline_sequencer.md
PIPELINE_SEQUENCER -- requirements
Module: pipeline_sequencer

Interface
REQ-001 Parameter CNT_W, default 16, width of the stall and flush event counters.
REQ-002 Port CLK  in  1  pipeline clock; all state updates on the rising edge.
REQ-003 Port RST  in  1  reset; synchronous, active-high.
REQ-004 Port ihit  in  1  instruction memory returned the fetch word this cycle.
REQ-005 Port dhit  in  1  data memory completed the MEM-stage access this cycle.
REQ-006 Port fd_rs, fd_rt  in  5 each  source register fields of the instruction in the FD latch output.
REQ-007 Port de_rt  in  5  rt field of the DE latch output; de_dcuREN  in  1  DE latch output holds a load.
REQ-008 Port em_dcuREN, em_dcuWEN  in  1 each  EM latch output holds a load or a store.
REQ-009 Port em_redirect  in  1  taken branch or jump resolved in MEM (EM pc_src nonzero and condition met).
REQ-010 Port mw_halt  in  1  MW latch output holds a halt.
REQ-011 Ports pc_en, fd_en, de_en, em_en, mw_en  out  1 each  write enables for the PC and the four pipeline latches.
REQ-012 Ports fd_flush, de_flush, em_flush, mw_flush  out  1 each  load a zero bubble (all control fields 0) into the latch on this edge; flush wins over the enable.
REQ-013 Port dmem_req  out  1  qualifies the MEM-stage data request toward the cache.
REQ-014 Port halt  out  1  sticky processor-halted indication.
REQ-015 Ports stall_cnt, flush_cnt  out  CNT_W each  saturating event counters.

Function
REQ-016 The FSM SHALL have states RUN, DWAIT and HALTED; all outputs not listed for a state SHALL be 0.
REQ-017 In HALTED, all enables, all flushes and dmem_req SHALL be 0, halt SHALL be 1, and the FSM SHALL stay in HALTED until RST.
REQ-018 From RUN or DWAIT, mw_halt=1 SHALL move the FSM to HALTED on the next edge, with all enables 0 in that cycle.
REQ-019 The per-cycle decision SHALL follow this priority: halt > data wait > redirect > load-use > fetch wait > advance.
REQ-020 Data wait: (em_dcuREN|em_dcuWEN)=1 and dhit=0 SHALL give pc_en=fd_en=de_en=em_en=0, mw_flush=1 and dmem_req=1, and the FSM SHALL enter or remain in DWAIT.
REQ-021 In DWAIT, dhit=1 SHALL advance all stages (all enables 1, dmem_req=1) and return the FSM to RUN on the same edge.
REQ-022 A MEM access in RUN with dhit=1 in the same cycle SHALL advance without entering DWAIT.
REQ-023 Redirect: em_redirect=1 SHALL give fd_flush=de_flush=em_flush=1, mw_en=1 and pc_en=1, independent of ihit; the in-flight fetch is discarded.
REQ-024 Load-use: de_dcuREN=1, de_rt!=0 and (de_rt==fd_rs or de_rt==fd_rt) SHALL give pc_en=fd_en=0, de_flush=1 and em_en=mw_en=1, for exactly one cycle per occurrence.
REQ-025 Fetch wait: ihit=0 SHALL give pc_en=fd_en=0, de_flush=1 and em_en=mw_en=1.
REQ-026 Advance: all enables SHALL be 1 and all flushes 0.
REQ-027 dmem_req SHALL equal (em_dcuREN|em_dcuWEN) in RUN and DWAIT and SHALL be 0 in HALTED.
REQ-028 stall_cnt SHALL increment on every cycle in which pc_en=0 outside HALTED.
REQ-029 flush_cnt SHALL increment on every redirect cycle.
REQ-030 Both counters SHALL saturate at all-ones and not wrap.
REQ-031 All outputs except the counters and halt SHALL be combinational from the current state and inputs, with zero-cycle latency.

Reset
REQ-032 While RST=1 on an edge, the FSM SHALL go to RUN, stall_cnt, flush_cnt and halt SHALL clear to 0, and all enables SHALL be 0 during the cycle RST is high.
REQ-033 RST asserted in DWAIT or HALTED SHALL return the FSM to RUN on that edge, and the first cycle after RST SHALL be evaluated as RUN.

Verification
REQ-034 Load-use: de_dcuREN=1, de_rt=8, fd_rs=8, ihit=1 for 1 cycle -> pc_en=0, fd_en=0, de_flush=1, em_en=1; stall_cnt goes 0->1.
REQ-035 Data wait: em_dcuREN=1 with dhit=0 for 3 cycles, then 1 -> FSM in DWAIT for 3 cycles, mw_flush=1 and dmem_req=1 throughout, all enables 1 on the dhit cycle, FSM back in RUN, stall_cnt=3.
REQ-036 Redirect coinciding with load-use and ihit=0 -> fd_flush=de_flush=em_flush=1, pc_en=1; flush_cnt=1; stall_cnt unchanged.
REQ-037 Redirect during a data wait (em_dcuWEN=1, dhit=0, em_redirect=1) -> data wait wins: no flushes except mw_flush, pc_en=0.
REQ-038 mw_halt=1 -> halt=1 from the next cycle, all enables 0, unaffected by further ihit/dhit activity; RST=1 for one edge -> halt=0, FSM in RUN, counters 0.
REQ-039 With CNT_W=4, 20 consecutive fetch-wait cycles -> stall_cnt=15 and held at 15.
